// File: rtl/wb_dual_master_arb_pkg.sv
// Shared types and constants for the dual-master Wishbone arbiter.
package wb_dual_master_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_D = 2'd1,
    ST_GNT_I = 2'd2
  } arb_state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
  localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
  localparam logic        RST_ENABLE       = 1'b1;

  // Bits needed to hold values 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Counts cycles a transfer has been granted; flags the last allowed cycle.
module wb_timeout_cnt
  import wb_dual_master_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = cnt_width(TIMEOUT_CYC);

  logic [W-1:0] count_q, count_d;

  assign expired = (count_q == W'(TIMEOUT_CYC - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_dual_master_arb.sv
// Arbitrates the core's I and D Wishbone masters onto one slave port,
// with I-starvation protection and a bus timeout that forces completion.
module wb_dual_master_arb
  import wb_dual_master_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter int unsigned STARVE_MAX  = 4,
  parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] i_data_o,
  output logic        i_ack_o,
  input  logic [31:0] i_addr_i,
  input  logic        i_stb_i,
  input  logic        i_cyc_i,
  output logic [31:0] d_data_o,
  output logic        d_ack_o,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_data_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_sel_i,
  input  logic        d_stb_i,
  input  logic        d_cyc_i,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  output logic        timeout_o
);

  localparam int unsigned SW = cnt_width(STARVE_MAX);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          req_i, req_d;
  logic          granted, m_cyc, m_stb;
  logic          fire_tmo, ack_out;
  logic [31:0]   data_out;
  logic          tmo_expired;

  assign req_i   = i_cyc_i & i_stb_i;
  assign req_d   = d_cyc_i & d_stb_i;
  assign granted = (state_q != ST_IDLE);

  wb_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (!granted),
    .enable (granted),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      ST_IDLE: begin
        // Counter can only reach STARVE_MAX: at that value I wins and it clears.
        if (req_i && req_d) begin
          if (starve_q == SW'(STARVE_MAX)) begin
            state_d  = ST_GNT_I;
            starve_d = '0;
          end else begin
            state_d  = ST_GNT_D;
            starve_d = starve_q + SW'(1);
          end
        end else if (req_i) begin
          state_d  = ST_GNT_I;
          starve_d = '0;
        end else begin
          if (req_d) begin
            state_d = ST_GNT_D;
          end
          starve_d = '0;
        end
      end
      ST_GNT_D, ST_GNT_I: begin
        if (!m_cyc || s_ack_i || tmo_expired) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_addr_o = ZERO_WORD;
    s_data_o = ZERO_WORD;
    s_we_o   = 1'b0;
    s_sel_o  = 4'h0;
    m_cyc    = 1'b0;
    m_stb    = 1'b0;
    case (state_q)
      ST_GNT_D: begin
        s_addr_o = d_addr_i;
        s_data_o = d_data_i;
        s_we_o   = d_we_i;
        s_sel_o  = d_sel_i;
        m_cyc    = d_cyc_i;
        m_stb    = d_stb_i;
      end
      ST_GNT_I: begin
        s_addr_o = i_addr_i;
        s_sel_o  = 4'hF;
        m_cyc    = i_cyc_i;
        m_stb    = i_stb_i;
      end
      default: ;
    endcase

    // A dropped cyc is a flush: no ack and no timeout for that master.
    fire_tmo  = granted & m_cyc & ~s_ack_i & tmo_expired;
    ack_out   = granted & m_cyc & (s_ack_i | tmo_expired);
    data_out  = fire_tmo ? ERR_DATA : s_data_i;
    s_cyc_o   = m_cyc & ~fire_tmo;
    s_stb_o   = m_stb & m_cyc & ~fire_tmo;
    timeout_o = fire_tmo;

    d_ack_o  = (state_q == ST_GNT_D) & ack_out;
    d_data_o = (state_q == ST_GNT_D) ? data_out : ZERO_WORD;
    i_ack_o  = (state_q == ST_GNT_I) & ack_out;
    i_data_o = (state_q == ST_GNT_I) ? data_out : ZERO_WORD;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_wb_dual_master_arb.sv
// Self-checking bench for wb_dual_master_arb: vector table, directed corner cases, random vs. model.
module tb_wb_dual_master_arb;

  localparam int TO = 8;
  localparam int SM = 4;
  localparam logic [31:0] ERR   = 32'hDEADBEEF;
  localparam logic [31:0] D_ADR = 32'h80000010;
  localparam logic [31:0] D_DAT = 32'h12345678;
  localparam logic [31:0] I_ADR = 32'hBFC00000;
  localparam logic [31:0] S_DAT = 32'h3C1DBFC0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_data_o, d_data_o, s_addr_o, s_data_o;
  logic        i_ack_o, d_ack_o, s_we_o, s_stb_o, s_cyc_o, timeout_o;
  logic [3:0]  s_sel_o;
  logic [31:0] i_addr_i, d_addr_i, d_data_i, s_data_i;
  logic        i_stb_i, i_cyc_i, d_we_i, d_stb_i, d_cyc_i, s_ack_i;
  logic [3:0]  d_sel_i;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  wb_dual_master_arb #(.TIMEOUT_CYC(TO), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .i_data_o(i_data_o), .i_ack_o(i_ack_o), .i_addr_i(i_addr_i), .i_stb_i(i_stb_i), .i_cyc_i(i_cyc_i),
    .d_data_o(d_data_o), .d_ack_o(d_ack_o), .d_addr_i(d_addr_i), .d_data_i(d_data_i), .d_we_i(d_we_i),
    .d_sel_i(d_sel_i), .d_stb_i(d_stb_i), .d_cyc_i(d_cyc_i),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i), .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .timeout_o(timeout_o)
  );

  logic [137:0] outs;
  assign outs = {s_addr_o, s_data_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
                 i_ack_o, i_data_o, d_ack_o, d_data_o, timeout_o};

  typedef struct {
    logic ir; logic dr; logic ack;
    logic stb; logic [31:0] addr; logic we; logic [3:0] sel;
    logic i_ack; logic [31:0] i_data; logic d_ack; logic [31:0] d_data; logic tmo;
  } vec_t;
  vec_t tbl [9];

  // Behavioural reference: who owns the bus, how long it has waited, how often I was passed over.
  int m_owner;
  int m_wait;
  int m_starve;

  task automatic check(input string name, input logic [137:0] act, input logic [137:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic dr, input logic ack);
    @(negedge clk);
    i_cyc_i = ir; i_stb_i = ir;
    d_cyc_i = dr; d_stb_i = dr;
    s_ack_i = ack;
    #1;
  endtask

  task automatic set_fixed();
    i_addr_i = I_ADR; d_addr_i = D_ADR; d_data_i = D_DAT;
    d_we_i = 1'b1; d_sel_i = 4'hF; s_data_i = S_DAT;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    i_cyc_i = 1'b0; i_stb_i = 1'b0; d_cyc_i = 1'b0; d_stb_i = 1'b0; s_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_owner = 0; m_wait = 0; m_starve = 0;
  endtask

  task automatic model_expect(output logic [137:0] e);
    logic [31:0] sa, sd, id, dd;
    logic        we, stb, cyc, ia, da, to;
    logic [3:0]  sel;
    sa = '0; sd = '0; id = '0; dd = '0;
    we = 0; stb = 0; cyc = 0; ia = 0; da = 0; to = 0; sel = '0;
    if (m_owner == 1) begin
      sa = d_addr_i; sd = d_data_i; we = d_we_i; sel = d_sel_i;
      cyc = d_cyc_i; stb = d_stb_i && d_cyc_i; dd = s_data_i;
      if (d_cyc_i) begin
        if (s_ack_i) da = 1;
        else if (m_wait == TO - 1) begin da = 1; dd = ERR; to = 1; cyc = 0; stb = 0; end
      end
    end else if (m_owner == 2) begin
      sa = i_addr_i; sel = 4'hF;
      cyc = i_cyc_i; stb = i_stb_i && i_cyc_i; id = s_data_i;
      if (i_cyc_i) begin
        if (s_ack_i) ia = 1;
        else if (m_wait == TO - 1) begin ia = 1; id = ERR; to = 1; cyc = 0; stb = 0; end
      end
    end
    e = {sa, sd, we, sel, stb, cyc, ia, id, da, dd, to};
  endtask

  task automatic model_step();
    logic ri, rd, mc;
    ri = i_cyc_i && i_stb_i;
    rd = d_cyc_i && d_stb_i;
    if (rst) begin
      m_owner = 0; m_wait = 0; m_starve = 0;
    end else if (m_owner != 0) begin
      mc = (m_owner == 1) ? d_cyc_i : i_cyc_i;
      if (!mc || s_ack_i || m_wait == TO - 1) begin m_owner = 0; m_wait = 0; end
      else m_wait++;
    end else begin
      m_wait = 0;
      if (ri && rd) begin
        if (m_starve == SM) begin m_owner = 2; m_starve = 0; end
        else begin m_owner = 1; m_starve = (m_starve < SM) ? m_starve + 1 : SM; end
      end else if (ri) begin m_owner = 2; m_starve = 0; end
      else if (rd) begin m_owner = 1; m_starve = 0; end
      else m_starve = 0;
    end
  endtask

  initial begin
    logic [137:0] e;
    logic [31:0]  sdx;
    int           grants[$];
    int           exp_g[6];
    int           got, pulses;

    // Reset holds everything at zero even with both masters and the slave active.
    set_fixed();
    rst = 1'b1;
    i_cyc_i = 1; i_stb_i = 1; d_cyc_i = 1; d_stb_i = 1; s_ack_i = 1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", outs, 138'(0));
    @(negedge clk);
    rst = 1'b0;
    i_cyc_i = 0; i_stb_i = 0; d_cyc_i = 0; d_stb_i = 0; s_ack_i = 0;

    // D write then I read; slave data fixed at S_DAT.
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 4'h0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, D_ADR,  1'b1, 4'hF, 1'b0, 32'h0,  1'b0, S_DAT,  1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, D_ADR,  1'b1, 4'hF, 1'b0, 32'h0,  1'b0, S_DAT,  1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, D_ADR,  1'b1, 4'hF, 1'b0, 32'h0,  1'b1, S_DAT,  1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 4'h0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 4'h0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, I_ADR,  1'b0, 4'hF, 1'b0, S_DAT,  1'b0, 32'h0,  1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, I_ADR,  1'b0, 4'hF, 1'b1, S_DAT,  1'b0, 32'h0,  1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 4'h0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0};
    for (int k = 0; k < 9; k++) begin
      drive(tbl[k].ir, tbl[k].dr, tbl[k].ack);
      sdx = (tbl[k].stb && tbl[k].we) ? D_DAT : 32'h0;
      e = {tbl[k].addr, sdx, tbl[k].we, tbl[k].sel, tbl[k].stb, tbl[k].stb,
           tbl[k].i_ack, tbl[k].i_data, tbl[k].d_ack, tbl[k].d_data, tbl[k].tmo};
      $display("table vec %0d: ir=%0b dr=%0b ack=%0b -> s_stb=%0b i_ack=%0b d_ack=%0b",
               k, tbl[k].ir, tbl[k].dr, tbl[k].ack, s_stb_o, i_ack_o, d_ack_o);
      check($sformatf("table_%0d", k), outs, e);
    end

    // Starvation: both masters hold requests; slave acks on the first granted cycle.
    reset_dut();
    for (int c = 0; c < 60 && grants.size() < 6; c++) begin
      @(negedge clk);
      i_cyc_i = 1; i_stb_i = 1; d_cyc_i = 1; d_stb_i = 1; s_ack_i = 0;
      #1;
      if (s_cyc_o) begin
        s_ack_i = 1;
        #1;
        if (d_ack_o) grants.push_back(1);
        else if (i_ack_o) begin
          grants.push_back(2);
          check("starve_clear", 138'(dut.starve_q), 138'(0));
        end
      end
    end
    exp_g = '{1, 1, 1, 1, 2, 1};
    for (int k = 0; k < 6; k++) begin
      got = (k < grants.size()) ? grants[k] : 0;
      $display("starve txn %0d: granted %s", k, got == 1 ? "D" : got == 2 ? "I" : "none");
      check($sformatf("starve_grant_%0d", k), 138'(got), 138'(exp_g[k]));
    end

    // Timeout: slave silent, forced completion in the 8th granted cycle.
    reset_dut();
    pulses = 0;
    drive(0, 1, 0);
    for (int k = 1; k <= TO; k++) begin
      drive(0, 1, 0);
      pulses += int'(timeout_o);
      if (k == TO) begin
        $display("timeout txn: d_ack=%0b d_data=%h timeout=%0b", d_ack_o, d_data_o, timeout_o);
        check("tmo_last", 138'({d_ack_o, d_data_o, timeout_o, s_cyc_o, s_stb_o}),
              138'({1'b1, ERR, 1'b1, 1'b0, 1'b0}));
      end else begin
        check($sformatf("tmo_wait_%0d", k), 138'({d_ack_o, timeout_o, s_cyc_o}), 138'({1'b0, 1'b0, 1'b1}));
      end
    end
    drive(0, 0, 0);
    pulses += int'(timeout_o);
    check("tmo_idle_after", 138'({s_cyc_o, d_ack_o, timeout_o}), 138'(0));
    check("tmo_pulse_count", 138'(pulses), 138'(1));

    // Real ack on the timeout cycle wins.
    drive(0, 1, 0);
    for (int k = 1; k <= TO; k++) drive(0, 1, (k == TO));
    $display("ack-vs-timeout txn: d_ack=%0b d_data=%h timeout=%0b", d_ack_o, d_data_o, timeout_o);
    check("ack_beats_tmo", 138'({d_ack_o, d_data_o, timeout_o}), 138'({1'b1, S_DAT, 1'b0}));
    drive(0, 0, 0);

    // Flush: D drops cyc in grant cycle 2; pending I granted two cycles later.
    reset_dut();
    drive(1, 1, 0);
    check("flush_idle", 138'(s_cyc_o), 138'(0));
    drive(1, 1, 0);
    check("flush_gnt_d", 138'({s_cyc_o, s_addr_o}), 138'({1'b1, D_ADR}));
    drive(1, 0, 0);
    check("flush_drop", 138'({s_cyc_o, s_stb_o, d_ack_o, timeout_o}), 138'(0));
    drive(1, 0, 0);
    check("flush_gap", 138'(s_cyc_o), 138'(0));
    drive(1, 0, 0);
    check("flush_gnt_i", 138'({s_cyc_o, s_addr_o}), 138'({1'b1, I_ADR}));
    drive(1, 0, 1);
    $display("flush txn: I completes with i_ack=%0b", i_ack_o);
    check("flush_i_ack", 138'({i_ack_o, i_data_o}), 138'({1'b1, S_DAT}));

    // Reset during GNT_I abandons the transfer; a later I read completes.
    reset_dut();
    drive(1, 0, 0);
    drive(1, 0, 0);
    check("rst_mid_gnt", 138'(s_cyc_o), 138'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_outs", outs, 138'(0));
    drive(1, 0, 0);
    check("rst_regrant", 138'({s_cyc_o, s_addr_o}), 138'({1'b1, I_ADR}));
    drive(1, 0, 1);
    $display("post-reset txn: i_ack=%0b i_data=%h", i_ack_o, i_data_o);
    check("rst_after_ack", 138'({i_ack_o, i_data_o}), 138'({1'b1, S_DAT}));
    drive(0, 0, 0);

    // Random traffic against the reference model.
    reset_dut();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      i_cyc_i  = i_cyc_i ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 2) == 0);
      i_stb_i  = i_cyc_i ? ($urandom_range(0, 9) != 0) : 1'($urandom_range(0, 1));
      d_cyc_i  = d_cyc_i ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 2) == 0);
      d_stb_i  = d_cyc_i ? ($urandom_range(0, 9) != 0) : 1'($urandom_range(0, 1));
      i_addr_i = $urandom; d_addr_i = $urandom; d_data_i = $urandom; s_data_i = $urandom;
      d_we_i   = 1'($urandom_range(0, 1));
      d_sel_i  = 4'($urandom_range(0, 15));
      s_ack_i  = ($urandom_range(0, 5) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      #1;
      model_expect(e);
      if (e[0] || e[33] || e[66])
        $display("rand txn cycle %0d: master %s data %h%s", c, e[66] ? "I" : "D",
                 e[66] ? e[65:34] : e[32:1], e[0] ? " (timeout)" : "");
      check($sformatf("rand_c%0d", c), outs, e);
      model_step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
